// File: rtl/bcd_pkg.sv
// Shared types and helpers for the serial packed-BCD add/subtract datapath.
//   bcd_ctrl_state_t : controller FSM encoding (IDLE, RUN, DONE)
//   BCD_DIGIT_W      : bits per BCD digit
//   is_bcd_digit     : 1 when a nibble holds a legal decimal digit (0..9)
//   nines_comp_byte  : per-digit nine's complement of a 2-digit BCD byte
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_ctrl_state_t;

    localparam int BCD_DIGIT_W = 4;

    function automatic logic is_bcd_digit(input logic [3:0] d);
        return (d <= 4'd9);
    endfunction

    // 99 - b computed digit-wise; illegal digits simply wrap (result unspecified then).
    function automatic logic [7:0] nines_comp_byte(input logic [7:0] b);
        return {4'd9 - b[7:4], 4'd9 - b[3:0]};
    endfunction

endpackage

// File: rtl/bcd_byte_addsub.sv
// Combinational 2-digit packed-BCD adder: s = a + b + cin with per-digit
// decimal correction. Subtraction is done by the caller feeding the
// nine's complement of B and a carry-in of 1.
//   a, b : packed BCD bytes (digit 0 in [3:0])
//   cin  : decimal carry in
//   s    : packed BCD sum byte
//   cout : decimal carry out of the upper digit
module bcd_byte_addsub
    import bcd_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [4:0] lo_sum_s;
    logic [4:0] hi_sum_s;
    logic       lo_c_s;
    logic       hi_c_s;
    logic [3:0] lo_adj_s;
    logic [3:0] hi_adj_s;

    // Per-digit binary add, then +6 (mod 16) on any digit that exceeded 9.
    always_comb begin
        lo_sum_s = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
        lo_c_s   = (lo_sum_s > 5'd9);
        lo_adj_s = lo_c_s ? (lo_sum_s[3:0] + 4'd6) : lo_sum_s[3:0];
        hi_sum_s = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'd0, lo_c_s};
        hi_c_s   = (hi_sum_s > 5'd9);
        hi_adj_s = hi_c_s ? (hi_sum_s[3:0] + 4'd6) : hi_sum_s[3:0];
        s        = {hi_adj_s, lo_adj_s};
        cout     = hi_c_s;
    end

endmodule

// File: rtl/bcd_serial_addsub_ctrl.sv
// Serial multi-digit packed-BCD add/subtract controller. Operands are
// accepted on a valid/ready handshake, then pushed one byte per cycle (LSB
// byte first) through a single 2-digit BCD byte adder; the result is
// offered on a second valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : operand handshake
//   in_a, in_b, in_sub    : packed BCD operands, 0 = A+B, 1 = A-B
//   out_valid/out_ready   : result handshake
//   out_res               : packed BCD result (10^DIGITS complement when A<B)
//   out_cy                : add: carry out, sub: borrow
//   out_err               : a non-BCD digit was present in the accepted operands
module bcd_serial_addsub_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_a,
    input  logic [4*DIGITS-1:0] in_b,
    input  logic                in_sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_res,
    output logic                out_cy,
    output logic                out_err
);

    localparam int W      = BCD_DIGIT_W * DIGITS;
    localparam int BYTE_W = 8;
    localparam int NBYTES = DIGITS / 2;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    if ((DIGITS % 2 != 0) || (DIGITS < 2)) begin : g_param_check
        $error("bcd_serial_addsub_ctrl: DIGITS must be even and >= 2");
    end

    bcd_ctrl_state_t state_r;
    bcd_ctrl_state_t state_next_s;

    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     res_r;
    logic             sub_r;
    logic             carry_r;
    logic             cy_r;
    logic             err_r;
    logic [IDX_W-1:0] idx_r;

    logic             err_s;
    logic [7:0]       b_op_s;
    logic [7:0]       sum_s;
    logic             cout_s;
    logic [W-1:0]     sum_ext_s;
    logic [W-1:0]     res_next_s;

    // Flag any illegal digit in the operands currently presented.
    always_comb begin
        err_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            err_s = err_s | ~is_bcd_digit(in_a[i*4 +: 4]) | ~is_bcd_digit(in_b[i*4 +: 4]);
        end
    end

    // Operand byte feed; subtraction uses the nine's complement plus the initial carry of 1.
    always_comb begin
        b_op_s     = sub_r ? nines_comp_byte(b_r[7:0]) : b_r[7:0];
        sum_ext_s  = W'(sum_s);
        res_next_s = (res_r >> BYTE_W) | (sum_ext_s << (W - BYTE_W));
    end

    bcd_byte_addsub u_byte (
        .a    (a_r[7:0]),
        .b    (b_op_s),
        .cin  (carry_r),
        .s    (sum_s),
        .cout (cout_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = in_valid ? RUN : IDLE;
            RUN:     state_next_s = (idx_r == IDX_LAST) ? DONE : RUN;
            DONE:    state_next_s = out_ready ? IDLE : DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Datapath: operand capture, byte-serial shift, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            cy_r    <= 1'b0;
            err_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        sub_r   <= in_sub;
                        carry_r <= in_sub;
                        err_r   <= err_s;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    // Operands shift down so the active byte is always [7:0];
                    // results enter at the top and land in place after NBYTES steps.
                    a_r     <= a_r >> BYTE_W;
                    b_r     <= b_r >> BYTE_W;
                    res_r   <= res_next_s;
                    carry_r <= cout_s;
                    idx_r   <= idx_r + 1'b1;
                    if (idx_r == IDX_LAST) begin
                        cy_r <= sub_r ? ~cout_s : cout_s;
                    end
                end
                DONE: begin
                    res_r <= res_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE);
    assign out_res   = res_r;
    assign out_cy    = cy_r;
    assign out_err   = err_r;

endmodule
